ram_copy_master: RTL



---
 rtl/ram_copy_master.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ram_copy_master.sv
// ram_copy_master
//
// Avalon-MM master that copies a block of 32-bit words from one word-address
// range to another on the same bus as the on-chip RAM slaves. One transaction
// is outstanding at a time: read a word, wait for its data, write it, repeat.
// The copy runs strictly ascending and pointers wrap modulo 2^ADDR_W.
//
// Optional feature: define RAM_COPY_MASTER_CHECKSUM_EN to add a 32-bit
// running sum of every word read during the copy.
//
// Parameters:
//   ADDR_W  word-address width (must match the slave)
//   LEN_W   width of the length field in words
//
// Ports:
//   clk                in   single rising-edge clock
//   reset              in   synchronous, active-high reset
//   start              in   one-cycle command strobe, only honoured in IDLE
//   src_addr           in   first source word address
//   dst_addr           in   first destination word address
//   length             in   number of words to copy (0 = no bus traffic)
//   busy               out  high from the cycle after start through DONE
//   done               out  one-cycle completion pulse
//   avm_address        out  word address
//   avm_read           out  read strobe
//   avm_write          out  write strobe
//   avm_writedata      out  write data
//   avm_byteenable     out  constant 4'hF
//   avm_waitrequest    in   slave stall, command accepted when low
//   avm_readdata       in   read data
//   avm_readdatavalid  in   qualifies avm_readdata
//   checksum           out  sum of words read (only with the macro defined)

module ram_copy_master #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
`ifdef RAM_COPY_MASTER_CHECKSUM_EN
  input  logic              avm_readdatavalid,
  output logic [31:0]       checksum
`else
  input  logic              avm_readdatavalid
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] src_ptr, src_ptr_n;
  logic [ADDR_W-1:0] dst_ptr, dst_ptr_n;
  logic [LEN_W-1:0]  remaining, remaining_n;
  logic [ADDR_W-1:0] address_n;
  logic [31:0]       writedata_n;
  logic              read_n, write_n, done_n, busy_n;
`ifdef RAM_COPY_MASTER_CHECKSUM_EN
  logic [31:0]       checksum_n;
`endif

  // Whole words are always transferred, so every byte lane is enabled.
  assign avm_byteenable = 4'hF;

  // Next-state and next-output logic. Outputs are registered, so they are
  // derived from the state being entered rather than the current one; this
  // keeps the strobes aligned with the state they belong to. The write-data
  // register doubles as the single-word copy buffer.
  always_comb begin
    state_n     = state;
    src_ptr_n   = src_ptr;
    dst_ptr_n   = dst_ptr;
    remaining_n = remaining;
    writedata_n = avm_writedata;
`ifdef RAM_COPY_MASTER_CHECKSUM_EN
    checksum_n  = checksum;
`endif

    case (state)
      IDLE: begin
        if (start) begin
`ifdef RAM_COPY_MASTER_CHECKSUM_EN
          checksum_n = 32'h0;
`endif
          if (length != '0) begin
            src_ptr_n   = src_addr;
            dst_ptr_n   = dst_addr;
            remaining_n = length;
            state_n     = RD_REQ;
          end else begin
            state_n = DONE;
          end
        end
      end

      RD_REQ: begin
        if (!avm_waitrequest) begin
          state_n = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (avm_readdatavalid) begin
          writedata_n = avm_readdata;
`ifdef RAM_COPY_MASTER_CHECKSUM_EN
          checksum_n  = checksum + avm_readdata;
`endif
          state_n     = WR_REQ;
        end
      end

      WR_REQ: begin
        if (!avm_waitrequest) begin
          src_ptr_n   = src_ptr + ADDR_W'(1);
          dst_ptr_n   = dst_ptr + ADDR_W'(1);
          remaining_n = remaining - LEN_W'(1);
          // Compare against the pre-decrement count: 1 means this was the last word.
          if (remaining == LEN_W'(1)) begin
            state_n = DONE;
          end else begin
            state_n = RD_REQ;
          end
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    read_n  = (state_n == RD_REQ);
    write_n = (state_n == WR_REQ);
    done_n  = (state_n == DONE);
    busy_n  = (state_n != IDLE);

    // The address only moves when a command is being presented; during a
    // stall the pointers are unchanged, so the address is held stable.
    case (state_n)
      RD_REQ:  address_n = src_ptr_n;
      WR_REQ:  address_n = dst_ptr_n;
      default: address_n = avm_address;
    endcase
  end

  // State, pointers and all registered outputs. A synchronous reset returns
  // to IDLE with strobes low; any read response still in flight then arrives
  // in IDLE and is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      src_ptr       <= '0;
      dst_ptr       <= '0;
      remaining     <= '0;
      avm_address   <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= 32'h0;
      done          <= 1'b0;
      busy          <= 1'b0;
`ifdef RAM_COPY_MASTER_CHECKSUM_EN
      checksum      <= 32'h0;
`endif
    end else begin
      state         <= state_n;
      src_ptr       <= src_ptr_n;
      dst_ptr       <= dst_ptr_n;
      remaining     <= remaining_n;
      avm_address   <= address_n;
      avm_read      <= read_n;
      avm_write     <= write_n;
      avm_writedata <= writedata_n;
      done          <= done_n;
      busy          <= busy_n;
`ifdef RAM_COPY_MASTER_CHECKSUM_EN
      checksum      <= checksum_n;
`endif
    end
  end

endmodule
